// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seg_595 display chain.
//   BIN_W    - width of the binary value coming from the data generator
//   DIG_N    - number of packed BCD digits handed to the scanner
//   DIG_W    - width of one BCD digit
//   MAX_VAL  - largest value that fits in DIG_N digits; larger inputs saturate
//   state_t  - bin2bcd_seq FSM encoding (IDLE=0, SHIFT=1, DONE=2)
package seg_pkg;

  localparam int BIN_W = 20;
  localparam int DIG_N = 6;
  localparam int DIG_W = 4;
  localparam int SCR_W = DIG_W * DIG_N;
  localparam int CNT_W = $clog2(BIN_W);

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(999999);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [SCR_W-1:0] BCD_SAT  = {DIG_N{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble per-digit adjust.
//   din  - one BCD scratch digit
//   dout - din + 3 when din >= 5, otherwise din unchanged
// Purely combinational; no carry leaves the digit.
module bcd_add3
  import seg_pkg::*;
(
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one double-dabble
// iteration per clock, feeding the 7-segment scanner.
//   sys_clk   - system clock, rising edge
//   sys_rst   - asynchronous active-high reset
//   start     - conversion request, accepted only in IDLE or DONE
//   bin_in    - binary value, sampled on the edge that accepts start
//   busy      - high exactly while in SHIFT
//   done      - one-cycle pulse (the DONE state) when bcd_out/ovf update
//   bcd_out   - packed BCD result, digit 0 (units) in [3:0]; held between runs
//   ovf       - last accepted bin_in exceeded MAX_VAL (bcd_out then all 9s)
//   state_dbg - current FSM state (seg_pkg::state_t encoding)
//
// Handshake: start is a request sampled on each rising edge; it is taken
// only when the FSM is in IDLE or DONE and is dropped (not queued)
// otherwise. done is asserted for exactly one cycle, and bcd_out/ovf change
// only on the edge that enters DONE, so they are valid together with done
// and stay stable until the next DONE. Back-to-back requests from DONE give
// one result every BIN_W+1 cycles.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [SCR_W-1:0] bcd_out,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  state_t           state;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] scratch_adj;
  logic [SCR_W-1:0] scratch_nxt;
  logic [BIN_W-1:0] bin_reg;
  logic [CNT_W-1:0] cnt;
  logic             ovf_flag;

  // Add-3 adjust on every digit of the scratch before the shift.
  for (genvar g = 0; g < DIG_N; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[g*DIG_W +: DIG_W]),
      .dout (scratch_adj[g*DIG_W +: DIG_W])
    );
  end

  // Adjusted scratch shifted left, taking in the next binary MSB.
  assign scratch_nxt = {scratch_adj[SCR_W-2:0], bin_reg[BIN_W-1]};
  assign state_dbg   = state;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
      scratch  <= '0;
      bin_reg  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            bin_reg  <= bin_in;
            scratch  <= '0;
            cnt      <= '0;
            ovf_flag <= (bin_in > MAX_VAL);
          end
        end

        SHIFT: begin
          scratch <= scratch_nxt;
          // The bit leaving the scratch is rotated into the vacated binary
          // LSB; those low bits are never consumed again, so this only keeps
          // the combined {scratch, bin_reg} register a clean rotator.
          bin_reg <= {bin_reg[BIN_W-2:0], scratch_adj[SCR_W-1]};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= ovf_flag ? BCD_SAT : scratch_nxt;
            ovf     <= ovf_flag;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            bin_reg  <= bin_in;
            scratch  <= '0;
            cnt      <= '0;
            ovf_flag <= (bin_in > MAX_VAL);
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        ovf;
  logic [1:0]  state_dbg;

  int checks;
  int failures;

  bin2bcd_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. Runs one conversion and checks busy for 20 cycles,
  // the done cycle at +21, and the idle cycle after it.
  task automatic run_conv(input string tag, input logic [19:0] val,
                          input logic [23:0] exp_bcd, input logic exp_ovf);
    start  = 1'b1;
    bin_in = val;
    @(posedge sys_clk);
    #1;
    start  = 1'b0;
    bin_in = 20'($urandom_range(0, 20'hFFFFF));
    for (int i = 1; i <= 20; i++) begin
      @(negedge sys_clk);
      check({tag, "_busy"}, {30'd0, busy, done}, 32'h2);
    end
    @(negedge sys_clk);
    check({tag, "_done"}, {30'd0, busy, done}, 32'h1);
    check({tag, "_bcd"}, {8'd0, bcd_out}, {8'd0, exp_bcd});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    @(negedge sys_clk);
    check({tag, "_after"}, {6'd0, state_dbg, busy, done, bcd_out}, {6'd0, 2'd0, 2'b00, exp_bcd});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    sys_rst  = 1'b1;
    start    = 1'b0;
    bin_in   = 20'd0;

    // Reset held: outputs at reset values even with clocks running.
    repeat (3) @(negedge sys_clk);
    check("rst_held", {5'd0, state_dbg, busy, done, ovf, bcd_out}, 32'h0);
    sys_rst = 1'b0;
    // No start: stays idle with zero outputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      check("idle_quiet", {5'd0, state_dbg, busy, done, ovf, bcd_out}, 32'h0);
    end

    run_conv("c123456", 20'd123456, 24'h123456, 1'b0);
    run_conv("c0",      20'd0,      24'h000000, 1'b0);
    run_conv("c999999", 20'd999999, 24'h999999, 1'b0);
    run_conv("c1e6",    20'd1000000, 24'h999999, 1'b1);
    run_conv("cfffff",  20'hFFFFF,  24'h999999, 1'b1);
    run_conv("c42",     20'd42,     24'h000042, 1'b0);
    run_conv("c9",      20'd9,      24'h000009, 1'b0);

    // Mid-conversion start pulses with a different bin_in are ignored.
    start  = 1'b1;
    bin_in = 20'd7;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sys_clk);
      check("mid_busy", {30'd0, busy, done}, 32'h2);
      if (i == 5 || i == 10) begin
        start  = 1'b1;
        bin_in = 20'd999;
      end else begin
        start  = 1'b0;
      end
    end
    @(negedge sys_clk);
    check("mid_done", {30'd0, busy, done}, 32'h1);
    check("mid_bcd", {8'd0, bcd_out}, 32'h000007);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("mid_noqueue", {28'd0, state_dbg, busy, done}, 32'h0);
    end

    // start held high: a new conversion starts from DONE each time,
    // one done every 21 cycles; bin_in is re-sampled in each DONE cycle.
    start  = 1'b1;
    bin_in = 20'd7;
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge sys_clk);
        check("held_busy", {30'd0, busy, done}, 32'h2);
      end
      @(negedge sys_clk);
      check("held_done", {30'd0, busy, done}, 32'h1);
      case (k)
        0: begin check("held_bcd0", {8'd0, bcd_out}, 32'h000007); bin_in = 20'd314;  end
        1: begin check("held_bcd1", {8'd0, bcd_out}, 32'h000314); bin_in = 20'd2718; end
        default: begin check("held_bcd2", {8'd0, bcd_out}, 32'h002718); start = 1'b0; end
      endcase
    end
    @(negedge sys_clk);
    check("held_release", {28'd0, state_dbg, busy, done}, 32'h0);

    // Reset during cycle 10 of SHIFT aborts with no done pulse.
    run_conv("c42b", 20'd42, 24'h000042, 1'b0);
    start  = 1'b1;
    bin_in = 20'd123;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("abort_pre", {8'd0, busy, done, bcd_out}, {8'd0, 2'b10, 24'h000042});
    #2;
    sys_rst = 1'b1;
    #1;
    check("abort_rst", {5'd0, state_dbg, busy, done, ovf, bcd_out}, 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      check("abort_quiet", {5'd0, state_dbg, busy, done, ovf, bcd_out}, 32'h0);
    end
    run_conv("c55", 20'd55, 24'h000055, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using double-dabble (shift/add-3), one bit per clock.
- Sits directly upstream of the dynamic 7-segment scanner in the seg_595 display chain.
- Converts the binary value from the data generator into six packed BCD digits that the scanner consumes.
- Start/done handshake; result is held stable between conversions so the scanner can sample it at any time.

Parameters:
- BIN_W, 20, width of the binary input.
- DIG_N, 6, number of BCD digits produced.
- MAX_VAL, 999999, largest representable value; inputs above it saturate.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; honoured only in IDLE or DONE.
- bin_in  input  BIN_W  binary value; sampled in the cycle start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIG_N  packed BCD result; digit 0 is in bits [3:0] (units); held between conversions.
- ovf  output  1  set when the last accepted bin_in exceeded MAX_VAL; updated together with bcd_out.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, bcd_out=0, ovf=0.
  - Internal shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> latch bin_in into the shift register, clear the BCD scratch and the counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch digit >=5 gets +3.
  - Then shift {scratch, binreg} left by 1.
  - Counter increments; after BIN_W iterations (counter==BIN_W-1 at the edge) go to DONE.
- DONE, lasts one cycle:
  - done=1.
  - bcd_out = scratch, or all digits 9 if the input exceeded MAX_VAL.
  - ovf reflects that comparison.
  - start=1 in DONE -> immediately begin a new conversion (go to SHIFT, latch bin_in). Otherwise go to IDLE.
- busy=1 exactly in SHIFT. done=1 exactly in DONE.
- Latency: start accepted at edge N -> done high during cycle N+BIN_W+1 -> with BIN_W=20, done appears 21 cycles after start.
- Throughput: back-to-back starts give one result every BIN_W+1 cycles.
- start while busy: ignored, not queued; bin_in changes while busy have no effect.
- Overflow check:
  - Performed on the latched bin_in, stored as a 1-bit flag at start acceptance.
  - ovf and saturation are applied at DONE.
- Scratch width is 4*DIG_N; add-3 is applied per 4-bit digit with no carry between digits (double-dabble guarantees no overflow for values <= 10^DIG_N-1).
- Reset mid-conversion: abort immediately, outputs return to reset values, no done pulse.
- bcd_out and ovf never change except in the DONE cycle or on reset.

Decomposition:
- Package seg_pkg holds:
  - BIN_W, DIG_N, MAX_VAL constants.
  - State encoding localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - BCD digit width constant (4).
- Sub-module bcd_add3: combinational per-digit adjust (in >=5 ? in+3 : in), 4-bit in/out, instantiated DIG_N times with a generate loop.
- Counter, FSM and saturation logic live in bin2bcd_seq.

Test Plan:
- Reset held, then released; no start -> busy=0, done=0, bcd_out=24'h000000, ovf=0 indefinitely.
- start with bin_in=20'd123456 -> busy high for 20 cycles; done pulse 21 cycles after start; bcd_out=24'h123456, ovf=0.
- bin_in=0 and bin_in=999999 -> bcd_out=24'h000000 and 24'h999999 respectively; ovf=0 both.
- bin_in=20'hFFFFF (1048575) -> bcd_out=24'h999999, ovf=1. A following conversion of 42 -> bcd_out=24'h000042, ovf=0.
- start pulsed at cycles 5 and 10 of a conversion of 7, plus start held high continuously:
  - Mid-conversion pulses ignored.
  - With start held, a new conversion begins from DONE each time; done pulses every 21 cycles.
- sys_rst asserted during cycle 10 of SHIFT with the previous bcd_out=24'h000042 -> outputs immediately zero, no done pulse. After release, a fresh start of 55 -> 24'h000055.
